reg_file_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 87 ++++++++
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared widths for the register file, the decode unit and the
//            hazard unit. Holds the default data width, register count and
//            read-port count, plus the address-width derivation.
// Ports    : none (package)
// Options  : none
// Revision : 1.0  initial release
// ============================================================================
package rf_pkg;

    localparam int DEF_DSIZE = 16;
    localparam int DEF_NREG  = 16;
    localparam int DEF_NRD   = 2;

    // Address width for a register file of nreg entries.
    function automatic int rsize_of(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Per-register pending-write tracker. Owns the busy vector, the
//            issue/writeback/flush priority and the registered pending count.
// Ports    : Clock, Reset (async, active-low)
//            raddr      packed read addresses, one RSIZE slice per port
//            wen/waddr  writeback clears the destination busy flag
//            issue_en/issue_addr  marks a destination as pending
//            flush      clears every busy flag
//            rbusy      per-port busy flag of the addressed register
//            pend_cnt   number of busy registers after the last edge
// Options  : REGFILE_BYPASS_EN - a same-cycle writeback to a port's address
//            reports that port not busy unless it is re-issued this cycle.
// Revision : 1.0  initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREG  = DEF_NREG,
    parameter  int NRD   = DEF_NRD,
    localparam int RSIZE = rsize_of(NREG)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NRD*RSIZE-1:0] raddr,
    input  logic                 wen,
    input  logic [RSIZE-1:0]     waddr,
    input  logic                 issue_en,
    input  logic [RSIZE-1:0]     issue_addr,
    input  logic                 flush,
    output logic [NRD-1:0]       rbusy,
    output logic [RSIZE:0]       pend_cnt
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [RSIZE:0]  cnt_nxt;

    // Writeback clears first, then issue sets, so a same-cycle issue to the
    // written register leaves it busy (the newer instruction owns it).
    // Flush overrides any issue but never blocks the data write.
    always_comb begin
        busy_nxt = busy;
        if (wen && (waddr != '0)) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_en && (issue_addr != '0)) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + {{RSIZE{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [RSIZE-1:0] addr;
        assign addr = raddr[p*RSIZE +: RSIZE];
`ifdef REGFILE_BYPASS_EN
        // A matching writeback resolves the hazard this cycle; the next-state
        // flag also captures a same-cycle re-issue (and flush priority).
        assign rbusy[p] = (wen && (waddr == addr) && (addr != '0))
                        ? busy_nxt[addr] : busy[addr];
`else
        assign rbusy[p] = busy[addr];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Parametrised multi-read-port register file with a per-register
//            pending-write scoreboard. R0 reads as zero and is never busy.
// Ports    : Clock, Reset (async, active-low)
//            RAddr/RData  packed read ports, port i at [i*W +: W]
//            RBusy/Stall  per-port pending flag and their OR
//            Wen/WAddr/WData      writeback port
//            IssueEn/IssueAddr    destination issue (marks pending)
//            Flush                clears all pending flags
//            PendCnt              registered count of busy registers
// Options  : REGFILE_BYPASS_EN - forward same-cycle writeback data to any
//            read port addressing the written register.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int DSIZE = DEF_DSIZE,
    parameter  int NREG  = DEF_NREG,
    parameter  int NRD   = DEF_NRD,
    localparam int RSIZE = rsize_of(NREG)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NRD*RSIZE-1:0] RAddr,
    output logic [NRD*DSIZE-1:0] RData,
    output logic [NRD-1:0]       RBusy,
    output logic                 Stall,
    input  logic                 Wen,
    input  logic [RSIZE-1:0]     WAddr,
    input  logic [DSIZE-1:0]     WData,
    input  logic                 IssueEn,
    input  logic [RSIZE-1:0]     IssueAddr,
    input  logic                 Flush,
    output logic [RSIZE:0]       PendCnt
);

    logic [DSIZE-1:0] mem [NREG];

    // Entry 0 is held at zero by reset and never written.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (Wen && (WAddr != '0)) begin
            mem[WAddr] <= WData;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [RSIZE-1:0] addr;
        logic [DSIZE-1:0] data;
        assign addr = RAddr[p*RSIZE +: RSIZE];

        always_comb begin
            data = '0;
            if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (Wen && (WAddr == addr)) begin
                    data = WData;
                end else begin
                    data = mem[addr];
                end
`else
                data = mem[addr];
`endif
            end
        end

        assign RData[p*DSIZE +: DSIZE] = data;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .Clock      (Clock),
        .Reset      (Reset),
        .raddr      (RAddr),
        .wen        (Wen),
        .waddr      (WAddr),
        .issue_en   (IssueEn),
        .issue_addr (IssueAddr),
        .flush      (Flush),
        .rbusy      (RBusy),
        .pend_cnt   (PendCnt)
    );

    assign Stall = |RBusy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Self-checking bench for reg_file_sb (default 16x16, 2 ports)
//            plus a 32-register, 3-port instance for multi-port reads.
// Ports    : none
// Options  : REGFILE_BYPASS_EN - reference model forwards same-cycle writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int NREG = 16;
    localparam int NRD  = 2;
    localparam int RS   = 4;
    localparam int DS   = 16;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [NRD*RS-1:0] RAddr = '0;
    logic [NRD*DS-1:0] RData;
    logic [NRD-1:0]    RBusy;
    logic              Stall;
    logic              Wen = 1'b0;
    logic [RS-1:0]     WAddr = '0;
    logic [DS-1:0]     WData = '0;
    logic              IssueEn = 1'b0;
    logic [RS-1:0]     IssueAddr = '0;
    logic              Flush = 1'b0;
    logic [RS:0]       PendCnt;

    // Wide instance: 32 registers, 3 read ports.
    logic [14:0] RAddr2 = '0;
    logic [47:0] RData2;
    logic [2:0]  RBusy2;
    logic        Stall2;
    logic        Wen2 = 1'b0;
    logic [4:0]  WAddr2 = '0;
    logic [15:0] WData2 = '0;
    logic [5:0]  PendCnt2;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DS-1:0] mem_m  [NREG];
    bit            busy_m [NREG];

    always #5 Clock = ~Clock;

    reg_file_sb dut (
        .Clock(Clock), .Reset(Reset), .RAddr(RAddr), .RData(RData),
        .RBusy(RBusy), .Stall(Stall), .Wen(Wen), .WAddr(WAddr),
        .WData(WData), .IssueEn(IssueEn), .IssueAddr(IssueAddr),
        .Flush(Flush), .PendCnt(PendCnt)
    );

    reg_file_sb #(.DSIZE(16), .NREG(32), .NRD(3)) dut2 (
        .Clock(Clock), .Reset(Reset), .RAddr(RAddr2), .RData(RData2),
        .RBusy(RBusy2), .Stall(Stall2), .Wen(Wen2), .WAddr(WAddr2),
        .WData(WData2), .IssueEn(1'b0), .IssueAddr(5'd0),
        .Flush(1'b0), .PendCnt(PendCnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    function automatic int model_pend();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += busy_m[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [DS-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (Wen && int'(WAddr) == a) return WData;
`endif
        return mem_m[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (Wen && int'(WAddr) == a) return IssueEn && int'(IssueAddr) == a && !Flush;
`endif
        return busy_m[a];
    endfunction

    // Apply the spec's edge rules to the model using the inputs present at the edge.
    task automatic model_edge();
        if (!Reset) begin
            model_reset();
            return;
        end
        if (Wen && WAddr != 0) mem_m[WAddr] = WData;
        if (Flush) begin
            for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
        end else begin
            if (Wen && WAddr != 0) busy_m[WAddr] = 1'b0;
            if (IssueEn && IssueAddr != 0) busy_m[IssueAddr] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit any = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            int a = int'(RAddr[p*RS +: RS]);
            chk($sformatf("rdata%0d@r%0d", p, a), 32'(RData[p*DS +: DS]), 32'(exp_data(a)));
            chk($sformatf("rbusy%0d@r%0d", p, a), 32'(RBusy[p]), 32'(exp_busy(a)));
            any |= exp_busy(a);
        end
        chk("stall", 32'(Stall), 32'(any));
        chk("pendcnt", 32'(PendCnt), 32'(model_pend()));
    endtask

    // Check mid-cycle, take one rising edge, update the model, settle.
    task automatic step();
        @(negedge Clock);
        check_outputs();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        Wen = 1'b0; IssueEn = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held: everything reads zero.
        RAddr = {4'd5, 4'd3};
        #1;
        chk("reset_rdata", 32'(RData), 32'd0);
        chk("reset_stall", 32'(Stall), 32'd0);
        chk("reset_pend", 32'(PendCnt), 32'd0);
        step();
        Reset = 1'b1;

        // R0 writes are discarded.
        Wen = 1'b1; WAddr = 4'd0; WData = 16'hFFFF; RAddr = {4'd0, 4'd0};
        step();
        idle();
        #1;
        chk("r0_read", 32'(RData), 32'd0);
        IssueEn = 1'b1; IssueAddr = 4'd0;
        step();
        idle();
        #1;
        chk("r0_issue_pend", 32'(PendCnt), 32'd0);

        // Write r7 while port 1 reads it.
        Wen = 1'b1; WAddr = 4'd7; WData = 16'hA5A5; RAddr = {4'd7, 4'd0};
        step();
        idle();
        #1;
        chk("wr_r7_next", 32'(RData[31:16]), 32'h0000A5A5);

        // Scoreboard: issue r4 then r9, read r4 on port 0.
        IssueEn = 1'b1; IssueAddr = 4'd4;
        step();
        IssueAddr = 4'd9;
        step();
        idle();
        RAddr = {4'd0, 4'd4};
        #1;
        chk("sb_rbusy0", 32'(RBusy[0]), 32'd1);
        chk("sb_stall", 32'(Stall), 32'd1);
        chk("sb_pend2", 32'(PendCnt), 32'd2);
        Wen = 1'b1; WAddr = 4'd4; WData = 16'h0042;
        step();
        idle();
        #1;
        chk("sb_rbusy0_clr", 32'(RBusy[0]), 32'd0);
        chk("sb_pend1", 32'(PendCnt), 32'd1);
        chk("sb_r4_data", 32'(RData[15:0]), 32'h00000042);

        // Issue and writeback to r3 together.
        IssueEn = 1'b1; IssueAddr = 4'd3; Wen = 1'b1; WAddr = 4'd3; WData = 16'hBEEF;
        RAddr = {4'd3, 4'd3};
        step();
        idle();
        #1;
        chk("sim_r3_data", 32'(RData[15:0]), 32'h0000BEEF);
        chk("sim_r3_busy", 32'(RBusy[0]), 32'd1);
        chk("sim_pend", 32'(PendCnt), 32'd2);
        Flush = 1'b1; IssueEn = 1'b1; IssueAddr = 4'd5;
        step();
        idle();
        #1;
        chk("flush_pend", 32'(PendCnt), 32'd0);

        // Wide instance: all three ports read r31.
        Wen2 = 1'b1; WAddr2 = 5'd31; WData2 = 16'h1234; RAddr2 = {5'd31, 5'd31, 5'd31};
        @(posedge Clock);
        #1;
        Wen2 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("wide_port%0d", p), 32'(RData2[p*16 +: 16]), 32'h00001234);
        end

        // Async reset mid-cycle, away from any edge.
        IssueEn = 1'b1; IssueAddr = 4'd7;
        step();
        idle();
        RAddr = {4'd7, 4'd3};
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        chk("areset_rdata", 32'(RData), 32'd0);
        chk("areset_pend", 32'(PendCnt), 32'd0);
        chk("areset_stall", 32'(Stall), 32'd0);
        chk("areset_wide", 32'(RData2[47:32]), 32'd0);
        step();
        Reset = 1'b1;

        // Randomized traffic with deliberate address collisions.
        for (int n = 0; n < 400; n++) begin
            Wen       = 1'($urandom % 2);
            WAddr     = 4'($urandom % NREG);
            WData     = 16'($urandom);
            IssueEn   = 1'($urandom % 2);
            IssueAddr = ($urandom % 4 == 0) ? WAddr : 4'($urandom % NREG);
            Flush     = ($urandom % 16 == 0);
            for (int p = 0; p < NRD; p++) begin
                RAddr[p*RS +: RS] = ($urandom % 3 == 0) ? WAddr : 4'($urandom % NREG);
            end
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
